// File: rtl/crc_engine_arbiter.sv
// crc_engine_arbiter: round-robin sharing of one bit-serial CRC engine
// between two requesters, with seed-load pulse, bit steering and capture.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req[1:0]              per-requester request, held until done/abort
//   data_valid/data_bit   per-requester serial stream
//   last[1:0]             last-bit flag, qualified by data_valid
//   grant[1:0]            registered one-hot grant
//   eng_load              one-cycle engine seed-load pulse
//   eng_en, eng_bit       engine shift enable and bit (STREAM only)
//   eng_crc               engine's current CRC register
//   done[1:0]             one-cycle completion pulse
//   result                captured CRC, held until next capture
//   err[1:0]              one-cycle timeout-abort pulse
//
// Optional feature: define CRC_ARB_TIMEOUT_EN to abort a STREAM that
// sees TIMEOUT consecutive cycles without a valid bit.

module crc_engine_arbiter #(
  parameter int CRC_WIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           data_valid,
  input  logic [1:0]           data_bit,
  input  logic [1:0]           last,
  output logic [1:0]           grant,
  output logic                 eng_load,
  output logic                 eng_en,
  output logic                 eng_bit,
  input  logic [CRC_WIDTH-1:0] eng_crc,
  output logic [1:0]           done,
  output logic [CRC_WIDTH-1:0] result,
  output logic [1:0]           err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 rr_q, rr_d;
  logic                 load_q, load_d;
  logic [1:0]           done_q, done_d;
  logic [CRC_WIDTH-1:0] result_q, result_d;
  logic [1:0]           err_q, err_d;

  // Grant is one-hot outside IDLE, so bit 1 is the granted index.
  logic g;
  logic strm;
  logic tmo;

  assign g    = grant_q[1];
  assign strm = (state_q == S_STREAM);

  assign eng_en  = strm & data_valid[g];
  assign eng_bit = strm & data_bit[g];

  assign grant    = grant_q;
  assign eng_load = load_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside STREAM, so it
  // restarts on every STREAM entry as well as on
  // every accepted bit.
  always_comb begin
    cnt_d = '0;
    tmo   = 1'b0;
    if (strm && !data_valid[g]) begin
      cnt_d = cnt_q + 1'b1;
      tmo   = (cnt_d == TW'(TIMEOUT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    load_d   = 1'b0;
    done_d   = '0;
    result_d = result_q;
    err_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          // rr_q has first claim; otherwise the
          // only remaining requester wins.
          if (req[rr_q]) begin
            grant_d = rr_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = rr_q ? 2'b01 : 2'b10;
          end
        end
      end
      S_LOAD: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!req[g]) begin
          state_d = S_IDLE;
          grant_d = '0;
          rr_d    = ~g;
        end else if (data_valid[g] && last[g]) begin
          state_d = S_FLUSH;
        end else if (tmo) begin
          state_d = S_IDLE;
          grant_d = '0;
          rr_d    = ~g;
          err_d   = g ? 2'b10 : 2'b01;
        end
      end
      S_FLUSH: begin
        // Engine has shifted the last bit by now.
        result_d = eng_crc;
        done_d   = grant_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        rr_d    = ~g;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      load_q   <= load_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_crc_engine_arbiter.sv
// tb_crc_engine_arbiter: scoreboard bench for crc_engine_arbiter with
// a CRC-8 (poly 0x07, init 0x00) engine and a division reference.
`timescale 1ns/1ps

module tb_crc_engine_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req = '0;
  logic [1:0] data_valid = '0;
  logic [1:0] data_bit = '0;
  logic [1:0] last = '0;
  logic [1:0] grant;
  logic       eng_load;
  logic       eng_en;
  logic       eng_bit;
  logic [7:0] eng_crc = 8'h00;
  logic [1:0] done;
  logic [7:0] result;
  logic [1:0] err;

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] sbq[$];
  bit         gq[$];
  int         gapq[$];
  bit         model_rr = 1'b0;
  logic [7:0] last_result = 8'h00;
  logic [1:0] err_allow = 2'b00;
  bit         pend = 1'b0;
  logic [7:0] pend_crc;
  logic [1:0] prev_g = 2'b00;
  int         idle_n = 0;

  crc_engine_arbiter #(.CRC_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data_valid(data_valid),
    .data_bit(data_bit),
    .last(last),
    .grant(grant),
    .eng_load(eng_load),
    .eng_en(eng_en),
    .eng_bit(eng_bit),
    .eng_crc(eng_crc),
    .done(done),
    .result(result),
    .err(err)
  );

  always #5 clk = ~clk;

  // Bit-serial engine living in the datapath.
  always @(posedge clk) begin
    if (eng_load)
      eng_crc <= 8'h00;
    else if (eng_en)
      eng_crc <= {eng_crc[6:0], 1'b0}
               ^ ((eng_crc[7] ^ eng_bit) ? 8'h07 : 8'h00);
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input bit m[64], input int n);
    bit d[72];
    logic [8:0] p;
    logic [7:0] rem;
    p = 9'h107;
    for (int i = 0; i < 72; i++) d[i] = (i < n) ? m[i] : 1'b0;
    for (int i = 0; i < n; i++)
      if (d[i])
        for (int j = 0; j < 9; j++) d[i+j] = d[i+j] ^ p[8-j];
    for (int j = 0; j < 8; j++) rem[7-j] = d[n+j];
    return rem;
  endfunction

  // Scoreboard / protocol monitor.
  always @(negedge clk) begin
    logic [8:0] ent;
    if (!rst_n) begin
      pend = 1'b0;
      prev_g = 2'b00;
      idle_n = 0;
    end else begin
      if (pend) begin
        chk("result", result, pend_crc);
        last_result = pend_crc;
        pend = 1'b0;
      end
      if (done != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          ent = sbq.pop_front();
          chk("done_id", done, ent[8] ? 2'b10 : 2'b01);
          pend = 1'b1;
          pend_crc = ent[7:0];
        end
      end
      chk("grant_overlap", grant == 2'b11, 0);
      chk("en_no_grant", eng_en && grant == 2'b00, 0);
      chk("err_unexpected", err & ~err_allow, 0);
      if (grant == 2'b00) begin
        idle_n++;
      end else begin
        if (prev_g == 2'b00) begin
          gq.push_back(grant[1]);
          gapq.push_back(idle_n);
        end
        idle_n = 0;
      end
      prev_g = grant;
    end
  end

  task automatic jam(input int o);
    data_valid[o] = 1'($urandom_range(0, 1));
    data_bit[o] = 1'($urandom_range(0, 1));
    last[o] = 1'($urandom_range(0, 1));
  endtask

  task automatic serve(input int r, input int n, input bit b[64],
                       input int gm, input int abort_at,
                       input bit junk, output int wt);
    logic [7:0] e;
    int t;
    int o;
    int gp;
    o = 1 - r;
    e = ref_crc(b, n);
    req[r] = 1'b1;
    t = 0;
    while (!grant[r] && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    wt = t;
    chk("grant_wait", grant[r], 1);
    if (!grant[r]) begin
      req[r] = 1'b0;
      return;
    end
    if (abort_at < 0) sbq.push_back({r[0], e});
    chk("eng_load_on", eng_load, 1);
    @(posedge clk); #1;
    chk("eng_load_off", eng_load, 0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        req[r] = 1'b0;
        data_valid[r] = 1'b0;
        last[r] = 1'b0;
        @(posedge clk); #1;
        chk("abort_grant", grant, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, last_result);
        return;
      end
      gp = (gm == 1) ? 1 : ((gm == 2) ? $urandom_range(0, 2) : 0);
      for (int k = 0; k < gp; k++) begin
        data_valid[r] = 1'b0;
        if (junk) jam(o);
        #1;
        chk("en_gap", eng_en, 0);
        @(posedge clk); #1;
      end
      data_valid[r] = 1'b1;
      data_bit[r] = b[i];
      last[r] = (i == n - 1);
      if (junk) jam(o);
      #1;
      chk("en_bit", {eng_en, eng_bit}, {1'b1, b[i]});
      @(posedge clk); #1;
    end
    data_valid[r] = 1'b0;
    last[r] = 1'b0;
    if (junk) begin
      data_valid[o] = 1'b0;
      last[o] = 1'b0;
    end
    chk("flush_en", eng_en, 0);
    t = 0;
    while (!done[r] && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_latency", t, 1);
    req[r] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pair(input bit a0, input bit a1,
                      input int n0, input int n1, input int gm);
    bit b0[64];
    bit b1[64];
    int w0;
    int w1;
    for (int i = 0; i < 64; i++) begin
      b0[i] = 1'($urandom_range(0, 1));
      b1[i] = 1'($urandom_range(0, 1));
    end
    gq.delete();
    gapq.delete();
    fork
      if (a0) serve(0, n0, b0, gm, -1, 1'b0, w0);
      if (a1) serve(1, n1, b1, gm, -1, 1'b0, w1);
    join
    if (a0 && a1) begin
      chk("grant_count", gq.size(), 2);
      if (gq.size() == 2) begin
        chk("first_winner", gq[0], model_rr);
        chk("second_winner", gq[1], !model_rr);
        chk("idle_gap", gapq[1], 1);
      end
    end else if (a0 || a1) begin
      model_rr = a0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit bb[64];
    int wt;
    int t;
    for (int i = 0; i < 64; i++) bb[i] = 1'b0;

    rst_n = 1'b0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_load", eng_load, 0);
    chk("rst_en", eng_en, 0);
    chk("rst_bit", eng_bit, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesting out of reset.
    pair(1'b1, 1'b1, 4, 5, 0);

    // Fixed frame 1,0,1,1 on requester 0.
    bb[0] = 1'b1; bb[1] = 1'b0; bb[2] = 1'b1; bb[3] = 1'b1;
    serve(0, 4, bb, 0, -1, 1'b0, wt);
    chk("grant_latency", wt, 1);
    model_rr = 1'b1;

    // Gapped 8-bit frame with noise on lane 1.
    for (int i = 0; i < 8; i++) bb[i] = 1'($urandom_range(0, 1));
    serve(0, 8, bb, 1, -1, 1'b1, wt);
    model_rr = 1'b1;

    // Abort requester 1 after three bits.
    serve(1, 6, bb, 0, 3, 1'b0, wt);
    model_rr = 1'b0;
    pair(1'b1, 1'b1, 3, 2, 2);

    // Asynchronous reset in the middle of a frame.
    req[0] = 1'b1;
    t = 0;
    while (!grant[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rstmid_grant", grant, 2'b01);
    @(posedge clk); #1;
    data_valid[0] = 1'b1;
    data_bit[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_grant0", grant, 0);
    chk("rstmid_load", eng_load, 0);
    chk("rstmid_en", eng_en, 0);
    chk("rstmid_bit", eng_bit, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_result", result, 0);
    chk("rstmid_err", err, 0);
    req = '0;
    data_valid = '0;
    data_bit = '0;
    last_result = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_rr = 1'b0;
    @(posedge clk); #1;
    pair(1'b1, 1'b0, 6, 1, 0);

    // Stall requester 0 in STREAM.
    req[0] = 1'b1;
    t = 0;
    while (!grant[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_grant", grant, 2'b01);
    @(posedge clk); #1;
`ifdef CRC_ARB_TIMEOUT_EN
    err_allow = 2'b01;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      if (j < 16) begin
        chk("tmo_err_low", err, 0);
      end else begin
        chk("tmo_err", err, 2'b01);
        chk("tmo_grant", grant, 0);
        chk("tmo_done", done, 0);
      end
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("tmo_err_pulse", err, 0);
    err_allow = 2'b00;
`else
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      chk("stall_err", err, 0);
      chk("stall_hold", grant, 2'b01);
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("stall_release", grant, 0);
`endif
    model_rr = 1'b1;

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      bit a0;
      bit a1;
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      if (!a0 && !a1) a0 = 1'b1;
      pair(a0, a1, $urandom_range(1, 20), $urandom_range(1, 20),
           $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
